// File: rtl/rcu_pll_seq_pkg.sv
// rcu_pll_seq_pkg: shared state encoding, default parameters and counter sizing for the PLL sequencer
package rcu_pll_seq_pkg;
  typedef enum logic [2:0] {IDLE, SW_OFF, PD, WAIT_LOCK, STABLE, SW_ON, RUN, ERR} state_e;
  localparam int DEF_CFG_WIDTH    = 3;
  localparam int DEF_SETTLE_CNT   = 16;
  localparam int DEF_LOCK_TIMEOUT = 4096;
  localparam int DEF_STABLE_CNT   = 64;
  localparam int DEF_SYNC_STAGES  = 2;
  function automatic int cnt_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/rcu_pll_seq_if.sv
// rcu_pll_seq_if: config request valid/ready handshake
interface rcu_pll_seq_if import rcu_pll_seq_pkg::*; #(parameter int CFG_WIDTH = DEF_CFG_WIDTH);
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [CFG_WIDTH-1:0] cfg_i;
  modport master (output cfg_valid_i, cfg_i, input cfg_ready_o);
  modport slave  (input cfg_valid_i, cfg_i, output cfg_ready_o);
endinterface

// File: rtl/rcu_pll_seq_sync_bit.sv
// sync_bit: multi-flop synchroniser for a single asynchronous bit, cleared by reset
module sync_bit import rcu_pll_seq_pkg::*; #(parameter int STAGES = DEF_SYNC_STAGES) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk) ff <= rst ? '0 : {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/rcu_pll_seq.sv
// rcu_pll_seq: PLL bring-up/reconfig sequencer; only hands the clock muxes to the PLL after stable lock
module rcu_pll_seq import rcu_pll_seq_pkg::*; #(
  parameter int CFG_WIDTH    = DEF_CFG_WIDTH,
  parameter int SETTLE_CNT   = DEF_SETTLE_CNT,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CNT   = DEF_STABLE_CNT,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rcu_pll_seq_if.slave         cfg_if,
  input  logic                 lock_i,
  output logic                 pll_en_o,
  output logic [CFG_WIDTH-1:0] clk_cfg_o,
  output logic                 sel_pll_o,
  output logic                 locked_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 lock_lost_o
);
  localparam int SW = cnt_w(SETTLE_CNT);
  localparam int BW = cnt_w(STABLE_CNT);
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CNT - 1);
  localparam logic [BW-1:0] STABLE_LAST = BW'(STABLE_CNT - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  state_e               state, nxt;
  logic                 lock_s, fire, settle_done, stable_done, timeout;
  logic [SW-1:0]        settle_q;
  logic [BW-1:0]        stable_q;
  logic [TW-1:0]        to_q;
  logic [CFG_WIDTH-1:0] cfg_q;
  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk_i), .rst(rst_i), .d(lock_i), .q(lock_s));
  assign cfg_if.cfg_ready_o = state inside {IDLE, RUN, ERR};
  assign fire        = cfg_if.cfg_valid_i && cfg_if.cfg_ready_o;
  assign settle_done = settle_q == SETTLE_LAST;
  assign stable_done = lock_s && stable_q == STABLE_LAST;
  assign timeout     = to_q == TO_LAST;
  assign sel_pll_o   = state inside {SW_ON, RUN};
  assign locked_o    = state == RUN;
  assign err_o       = state == ERR;
  // stable completion outranks a coincident timeout; a handshake in RUN outranks a lock drop
  always_comb begin
    nxt = state;
    case (state)
      IDLE, ERR: nxt = fire ? SW_OFF : state;
      SW_OFF:    nxt = settle_done ? PD : SW_OFF;
      PD:        nxt = settle_done ? WAIT_LOCK : PD;
      WAIT_LOCK: nxt = timeout ? ERR : lock_s ? STABLE : WAIT_LOCK;
      STABLE:    nxt = stable_done ? SW_ON : timeout ? ERR : lock_s ? STABLE : WAIT_LOCK;
      SW_ON:     nxt = settle_done ? RUN : SW_ON;
      RUN:       nxt = fire ? SW_OFF : lock_s ? RUN : WAIT_LOCK;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      settle_q    <= '0;
      stable_q    <= '0;
      to_q        <= '0;
      cfg_q       <= '0;
      clk_cfg_o   <= '0;
      pll_en_o    <= 1'b0;
      done_o      <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      state       <= nxt;
      settle_q    <= (nxt != state) ? '0 : settle_done ? settle_q : settle_q + 1'b1;
      stable_q    <= (state == STABLE && nxt == STABLE) ? stable_q + 1'b1 : '0;
      to_q        <= (nxt == WAIT_LOCK && !(state inside {WAIT_LOCK, STABLE})) ? '0 : timeout ? to_q : to_q + 1'b1;
      cfg_q       <= fire ? cfg_if.cfg_i : cfg_q;
      clk_cfg_o   <= (nxt == PD && state != PD) ? cfg_q : clk_cfg_o;
      pll_en_o    <= (nxt == WAIT_LOCK) ? 1'b1 : (nxt inside {PD, ERR, IDLE}) ? 1'b0 : pll_en_o;
      done_o      <= nxt == RUN && state != RUN;
      lock_lost_o <= fire ? 1'b0 : (state == RUN && !lock_s) ? 1'b1 : lock_lost_o;
    end
  end
endmodule

// File: tb/tb_rcu_pll_seq.sv
// tb_rcu_pll_seq: directed stimulus with a scoreboard of expected done/err/lock-lost events
module tb_rcu_pll_seq;
  localparam int K_DONE = 1, K_ERR = 2, K_LOST = 3;
  typedef struct {int kind; int cyc; logic [7:0] snap;} ev_t;
  logic clk = 1'b0, rst = 1'b1, lock = 1'b0;
  logic pll_en, sel_pll, locked, done, err, lock_lost;
  logic [2:0] clk_cfg;
  logic err_d = 1'b0, lost_d = 1'b0, started = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int t, d, x, a;
  ev_t exp_q[$];
  rcu_pll_seq_if #(.CFG_WIDTH(3)) bus ();
  rcu_pll_seq #(.CFG_WIDTH(3), .SETTLE_CNT(2), .LOCK_TIMEOUT(32), .STABLE_CNT(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_if(bus), .lock_i(lock), .pll_en_o(pll_en), .clk_cfg_o(clk_cfg),
    .sel_pll_o(sel_pll), .locked_o(locked), .done_o(done), .err_o(err), .lock_lost_o(lock_lost)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] snap();
    return {err, lock_lost, locked, sel_pll, pll_en, clk_cfg};
  endfunction
  function automatic logic [7:0] mk(input logic e, l, k, s, p, input logic [2:0] c);
    return {e, l, k, s, p, c};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask
  task automatic push(input int kind, input int c, input logic [7:0] s);
    exp_q.push_back('{kind: kind, cyc: c, snap: s});
  endtask
  task automatic req(input logic [2:0] c, output int acc);
    bus.cfg_valid_i = 1'b1;
    bus.cfg_i = c;
    for (int i = 0; i < 100 && !bus.cfg_ready_o; i++) tick();
    chk("req_ready", int'(bus.cfg_ready_o), 1);
    acc = cyc;
    tick();
    bus.cfg_valid_i = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pll_en"}, int'(pll_en), 0);
    chk({tag, "_sel"}, int'(sel_pll), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_lost"}, int'(lock_lost), 0);
    chk({tag, "_clk_cfg"}, int'(clk_cfg), 0);
    chk({tag, "_ready"}, int'(bus.cfg_ready_o), 1);
  endtask
  always @(negedge clk) if (started) begin
    automatic int kind = done ? K_DONE : (err && !err_d) ? K_ERR : (lock_lost && !lost_d) ? K_LOST : 0;
    automatic ev_t e;
    if (kind != 0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d snap %h, none expected", kind, cyc, snap());
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || e.cyc != cyc || e.snap != snap()) begin
          errors++;
          $display("FAIL event: got kind %0d cycle %0d snap %h, expected kind %0d cycle %0d snap %h",
                   kind, cyc, snap(), e.kind, e.cyc, e.snap);
        end
      end
    end
    err_d  <= err;
    lost_d <= lock_lost;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    bus.cfg_valid_i = 1'b0;
    bus.cfg_i = 3'd0;
    repeat (3) tick();
    chk_reset("rst");
    rst = 1'b0;
    started = 1'b1;
    // normal bring-up
    req(3'b101, t);
    push(K_DONE, t + 17, mk(0, 0, 1, 1, 1, 3'd5));
    wait_until(t + 2); chk("cfg_before_pd", int'(clk_cfg), 0);
    wait_until(t + 3); chk("cfg_at_pd", int'(clk_cfg), 5);
    wait_until(t + 4); chk("pll_en_in_pd", int'(pll_en), 0);
    wait_until(t + 5); chk("pll_en_wait", int'(pll_en), 1);
    wait_until(t + 8); lock = 1'b1;
    wait_until(t + 14); chk("sel_in_stable", int'(sel_pll), 0);
    wait_until(t + 15); chk("sel_sw_on", int'(sel_pll), 1);
    // lock loss in RUN and automatic relock
    d = t + 20;
    wait_until(d); lock = 1'b0;
    push(K_LOST, d + 3, mk(0, 1, 0, 0, 1, 3'd5));
    wait_until(d + 2); chk("sel_before_drop", int'(sel_pll), 1);
    wait_until(d + 3); chk("sel_after_drop", int'(sel_pll), 0);
    chk("locked_after_drop", int'(locked), 0);
    wait_until(d + 10); lock = 1'b1;
    push(K_DONE, d + 19, mk(0, 1, 1, 1, 1, 3'd5));
    // request and lock drop coincide in RUN, then timeout to ERR
    x = d + 22;
    wait_until(x); lock = 1'b0;
    wait_until(x + 2); chk("lost_sticky", int'(lock_lost), 1);
    req(3'b010, t);
    chk("accept_cycle", t, x + 2);
    push(K_ERR, t + 37, mk(1, 0, 0, 0, 0, 3'd2));
    chk("lost_cleared", int'(lock_lost), 0);
    chk("sel_sw_off", int'(sel_pll), 0);
    wait_until(t + 2); chk("cfg_old", int'(clk_cfg), 5);
    wait_until(t + 3); chk("cfg_new", int'(clk_cfg), 2);
    wait_until(t + 36); chk("err_before_to", int'(err), 0);
    chk("pll_en_before_to", int'(pll_en), 1);
    wait_until(t + 37); chk("ready_in_err", int'(bus.cfg_ready_o), 1);
    chk("pll_en_in_err", int'(pll_en), 0);
    // lock glitch in STABLE restarts the stable count
    req(3'b011, t);
    push(K_DONE, t + 19, mk(0, 0, 1, 1, 1, 3'd3));
    chk("err_cleared", int'(err), 0);
    wait_until(t + 6); lock = 1'b1;
    wait_until(t + 9); lock = 1'b0;
    wait_until(t + 10); lock = 1'b1;
    wait_until(t + 16); chk("glitch_sel_low", int'(sel_pll), 0);
    wait_until(t + 17); chk("glitch_sel_high", int'(sel_pll), 1);
    // stable completion on the same cycle as timeout
    wait_until(t + 21); lock = 1'b0;
    req(3'b110, t);
    push(K_DONE, t + 39, mk(0, 0, 1, 1, 1, 3'd6));
    wait_until(t + 30); lock = 1'b1;
    wait_until(t + 36); chk("edge_sel_low", int'(sel_pll), 0);
    wait_until(t + 37); chk("edge_sel_high", int'(sel_pll), 1);
    chk("edge_no_err", int'(err), 0);
    // reset during WAIT_LOCK with a stalled request held through it
    wait_until(t + 41); lock = 1'b0;
    req(3'b001, t);
    wait_until(t + 7);
    rst = 1'b1;
    bus.cfg_valid_i = 1'b1;
    bus.cfg_i = 3'b111;
    chk("stalled_ready", int'(bus.cfg_ready_o), 0);
    tick();
    rst = 1'b0;
    chk_reset("midrst");
    req(3'b111, a);
    chk("post_rst_accept", a, t + 8);
    chk("ready_sw_off", int'(bus.cfg_ready_o), 0);
    wait_until(a + 2); chk("rst_cfg_old", int'(clk_cfg), 0);
    wait_until(a + 3); chk("rst_cfg_new", int'(clk_cfg), 7);
    wait_until(a + 5); lock = 1'b1;
    push(K_DONE, a + 14, mk(0, 0, 1, 1, 1, 3'd7));
    wait_until(a + 18);
    chk("sb_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
